dfd_tnif_src_fifo: RTL and testbench

Per-source packet staging buffer that sits directly upstream of the trace network interface (one instance for the DST path, one for the NTR path). It accepts packed trace packets from the trace encoder and buffers them in a DEPTH-entry FIFO. It presents the head entry to the interface as a request/data pair and pops on pull. It also stalls the encoder on high-water or network backpressure, runs a flush-drain state machine, and counts dropped packets.

---
 rtl/dfd_tnif_src_fifo.sv | 96 +++++++++
 tb/tb_dfd_tnif_src_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dfd_tnif_src_fifo.sv
// rtl/dfd_tnif_src_fifo.sv - per-source trace packet staging FIFO with stall, flush-drain and drop counting
module dfd_tnif_src_fifo #(
    parameter int DATA_WIDTH_IN_BYTES = 4,
    parameter int DEPTH               = 8,
    parameter int STALL_MARGIN        = 2,
    parameter int DROP_CNT_WIDTH      = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               pkt_valid_in,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0]   pkt_data_in,
    output logic                               pkt_stall_out,
    output logic                               req_out,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]   data_out,
    input  logic                               pull_in,
    input  logic                               flush_in,
    input  logic                               bp_in,
    output logic                               flush_done_out,
    output logic [$clog2(DEPTH):0]             level_out,
    output logic [DROP_CNT_WIDTH-1:0]          drop_cnt_out,
    output logic                               ovf_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = DATA_WIDTH_IN_BYTES * 8;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t         state, state_next;
    logic [DW-1:0]  mem [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_next, wr_next, level_next;
    logic [PW:0]    free_next;
    logic           empty, full, pop, push, drop, stall_next;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign pop   = pull_in && !empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push  = pkt_valid_in && (state == IDLE) && (!full || pop);
    assign drop  = pkt_valid_in && !push;

    assign rd_next    = pop  ? rd_ptr + PW'(1) : rd_ptr;
    assign wr_next    = push ? wr_ptr + PW'(1) : wr_ptr;
    assign level_next = wr_next - rd_next;
    assign free_next  = (PW+1)'(DEPTH) - {1'b0, level_next};

    assign req_out  = !empty;
    assign data_out = req_out ? mem[rd_ptr[AW-1:0]] : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_in) state_next = DRAIN;
            DRAIN:   if (level_next == '0) state_next = DONE;
            DONE:    if (!flush_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // bp is ignored while the interface is flushing; a non-idle FSM always stalls.
    assign stall_next = (free_next <= (PW+1)'(STALL_MARGIN)) || (bp_in && !flush_in)
                        || (state_next != IDLE);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pkt_data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            level_out      <= '0;
            pkt_stall_out  <= 1'b0;
            flush_done_out <= 1'b0;
            drop_cnt_out   <= '0;
            ovf_out        <= 1'b0;
        end else begin
            state          <= state_next;
            rd_ptr         <= rd_next;
            wr_ptr         <= wr_next;
            level_out      <= level_next;
            pkt_stall_out  <= stall_next;
            flush_done_out <= (state_next == DONE);
            if (drop) begin
                ovf_out <= 1'b1;
                if (drop_cnt_out != {DROP_CNT_WIDTH{1'b1}})
                    drop_cnt_out <= drop_cnt_out + DROP_CNT_WIDTH'(1);
            end
        end
    end

    a_no_pop_empty:  assert property (@(posedge clock) disable iff (reset) !(pull_in && !req_out));
    a_level_bound:   assert property (@(posedge clock) disable iff (reset) level_out <= PW'(DEPTH));
    a_done_is_empty: assert property (@(posedge clock) disable iff (reset) flush_done_out |-> !req_out);
endmodule

// File: tb/tb_dfd_tnif_src_fifo.sv
// tb/tb_dfd_tnif_src_fifo.sv - vector table plus data scoreboard for dfd_tnif_src_fifo
module tb_dfd_tnif_src_fifo;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid_in = 1'b0;
    logic [31:0] pkt_data_in = '0;
    logic        pull_in = 1'b0, flush_in = 1'b0, bp_in = 1'b0;
    logic        pkt_stall_out, req_out, flush_done_out, ovf_out;
    logic [31:0] data_out;
    logic [3:0]  level_out;
    logic [7:0]  drop_cnt_out;
    logic        stall2, req2, done2, ovf2;
    logic [31:0] data2;
    logic [3:0]  level2;
    logic [1:0]  drop2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dfd_tnif_src_fifo #(.DATA_WIDTH_IN_BYTES(4), .DEPTH(8), .STALL_MARGIN(2), .DROP_CNT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .pkt_valid_in(pkt_valid_in), .pkt_data_in(pkt_data_in),
        .pkt_stall_out(pkt_stall_out), .req_out(req_out), .data_out(data_out), .pull_in(pull_in),
        .flush_in(flush_in), .bp_in(bp_in), .flush_done_out(flush_done_out), .level_out(level_out),
        .drop_cnt_out(drop_cnt_out), .ovf_out(ovf_out));

    dfd_tnif_src_fifo #(.DATA_WIDTH_IN_BYTES(4), .DEPTH(8), .STALL_MARGIN(2), .DROP_CNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .pkt_valid_in(pkt_valid_in), .pkt_data_in(pkt_data_in),
        .pkt_stall_out(stall2), .req_out(req2), .data_out(data2), .pull_in(pull_in),
        .flush_in(flush_in), .bp_in(bp_in), .flush_done_out(done2), .level_out(level2),
        .drop_cnt_out(drop2), .ovf_out(ovf2));

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        pull, flush, bp, acc;
        int          lvl;
        logic        stall;
        int          drop;
        logic        done;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    logic [31:0] exp_data;
    int          ed;

    function automatic void add(logic v, logic [31:0] d, logic p, logic f, logic b, logic a,
                                int lvl, logic st, int drp, logic dn);
        vec_t x;
        x.valid = v; x.data = d; x.pull = p; x.flush = f; x.bp = b; x.acc = a;
        x.lvl = lvl; x.stall = st; x.drop = drp; x.done = dn;
        vecs.push_back(x);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        ed = 0;
        for (int i = 1; i <= 8; i++) add(1, 32'(i), 0, 0, 0, 1, i, i >= 6, ed, 0);
        add(1, 32'h09, 1, 0, 0, 1, 8, 1, ed, 0);
        ed = 1; add(1, 32'hAA, 0, 0, 0, 0, 8, 1, ed, 0);
        for (int i = 7; i >= 0; i--) add(0, 0, 1, 0, 0, 0, i, i >= 6, ed, 0);
        add(1, 32'h11, 0, 0, 0, 1, 1, 0, ed, 0);
        add(1, 32'h12, 0, 0, 0, 1, 2, 0, ed, 0);
        add(1, 32'h13, 0, 0, 0, 1, 3, 0, ed, 0);
        add(0, 0, 1, 1, 0, 0, 2, 1, ed, 0);
        ed = 2; add(1, 32'h55, 1, 1, 0, 0, 1, 1, ed, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, ed, 1);
        ed = 3; add(1, 32'h66, 0, 1, 0, 0, 0, 1, ed, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, ed, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, ed, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, ed, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, ed, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, ed, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, ed, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, ed, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, ed, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, ed, 0);
        for (int i = 1; i <= 8; i++) add(1, 32'h20 + 32'(i), 0, 0, 0, 1, i, i >= 6, ed, 0);
        ed = 4; add(1, 32'hEE, 0, 0, 0, 0, 8, 1, ed, 0);
        ed = 5; add(1, 32'hEF, 0, 0, 0, 0, 8, 1, ed, 0);
        for (int i = 7; i >= 5; i--) add(0, 0, 1, 0, 0, 0, i, i >= 6, ed, 0);

        #12;
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_level", level_out, 0);
        chk("rst_stall", pkt_stall_out, 0);
        chk("rst_done", flush_done_out, 0);
        chk("rst_drop", drop_cnt_out, 0);
        chk("rst_ovf", ovf_out, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            pkt_valid_in = vecs[i].valid;
            pkt_data_in  = vecs[i].data;
            pull_in      = vecs[i].pull;
            flush_in     = vecs[i].flush;
            bp_in        = vecs[i].bp;
            #1;
            if (vecs[i].pull) begin
                chk($sformatf("req_pre_pull[%0d]", i), req_out, 1);
                if (sb.size() > 0) begin
                    exp_data = sb.pop_front();
                    chk($sformatf("head_data[%0d]", i), data_out, exp_data);
                end
            end
            if (vecs[i].acc) sb.push_back(vecs[i].data);
            @(posedge clock);
            #1;
            chk($sformatf("level[%0d]", i), level_out, vecs[i].lvl);
            chk($sformatf("req[%0d]", i), req_out, vecs[i].lvl != 0);
            chk($sformatf("stall[%0d]", i), pkt_stall_out, vecs[i].stall);
            chk($sformatf("drop[%0d]", i), drop_cnt_out, vecs[i].drop);
            chk($sformatf("ovf[%0d]", i), ovf_out, vecs[i].drop != 0);
            chk($sformatf("done[%0d]", i), flush_done_out, vecs[i].done);
            chk($sformatf("drop_sat[%0d]", i), drop2, (vecs[i].drop > 3) ? 3 : vecs[i].drop);
            if (vecs[i].lvl == 0) chk($sformatf("data_idle[%0d]", i), data_out, 0);
        end

        pkt_valid_in = 1'b0;
        pull_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_req", req_out, 0);
        chk("async_level", level_out, 0);
        chk("async_drop", drop_cnt_out, 0);
        chk("async_ovf", ovf_out, 0);
        chk("async_drop_sat", drop2, 0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();

        @(negedge clock);
        pkt_valid_in = 1'b1;
        pkt_data_in = 32'h77;
        @(posedge clock);
        #1;
        chk("post_rst_req", req_out, 1);
        chk("post_rst_data", data_out, 32'h77);
        chk("post_rst_level", level_out, 1);
        @(negedge clock);
        pkt_valid_in = 1'b0;
        pull_in = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_pop_req", req_out, 0);
        chk("post_rst_pop_level", level_out, 0);
        @(negedge clock);
        pull_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
